note_player: RTL and testbench
==============================

# note_player

Command-driven tone generator that sits directly upstream of the delta-sigma DAC stage and drives its signed 8-bit `sample` and `silent` inputs. It accepts note commands (pitch increment, duration, waveform) through a valid/ready handshake and buffers them in a small FIFO. It plays each note with a phase accumulator that advances at a fixed sample-rate tick derived from `clk`.

## Interface
- `SAMPLE_DIV`, 1024: `clk` cycles per sample tick; must be ≥2.
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals !full.
- `cmd_phase_inc`  in  16  phase increment per sample tick.
- `cmd_duration`  in  16  note length in sample ticks.
- `cmd_wave`  in  2  00 square, 01 saw, 10 triangle, 11 rest.
- `sample`  out  8  signed two's-complement sample to the DAC; registered.
- `silent`  out  1  DAC mute; registered.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

## Operation
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. `tick` is asserted in the cycle where count == SAMPLE_DIV-1. The counter runs free and is independent of the FSM.
- Push: a command is pushed when cmd_valid && cmd_ready. A push when full cannot occur.
- Pop: only from a non-empty FIFO. If a push and a pop occur in the same cycle, both take effect and the count is unchanged.
- FSM has three states:
  - IDLE: `silent`=1, `sample`=8'h00. Go to LOAD when the FIFO is non-empty.
  - LOAD, one cycle:
    - Pop the head entry; set phase=0 and dur=cmd_duration.
    - Set `sample`=wave(0) and `silent`=(wave==11).
    - If duration==0, go to IDLE (or stay in LOAD if the FIFO is still non-empty) and force `silent`=1, `sample`=0. Otherwise go to PLAY.
  - PLAY, on each tick:
    - Set phase += inc (modulo 2^16) and dur -= 1.
    - `sample` loads wave(new phase) on the same edge.
    - When dur goes from 1 to 0, the note ends:
      - FIFO non-empty: go to LOAD.
      - FIFO empty: go to IDLE with `silent`=1, `sample`=0.
- Waveforms, with p = phase:
  - square: p[15] ? 8'h81 : 8'h7F.
  - saw: p[15:8] ^ 8'h80.
  - triangle: t = p[15] ? ~p[14:7] : p[14:7]; sample = t ^ 8'h80.
  - rest: sample 8'h00 with `silent`=1 for the full duration.
- Reset, asserted at any time:
  - FIFO is flushed; FSM goes to IDLE; phase, dur and the tick counter are cleared.
  - Outputs: `sample`=8'h00, `silent`=1, `cmd_ready`=1, `busy`=0.

## Timing
- `cmd_ready` is combinational from the FIFO count only; it never depends on `cmd_valid`.
- A command pushed into an empty FIFO while the FSM is IDLE reaches LOAD 1 cycle after the push edge. Its outputs appear at the LOAD edge, 2 edges after the push.
- `sample` and `silent` change only on a LOAD edge, a PLAY tick edge, or the return to IDLE, and are stable between those edges.
- Back-to-back notes have exactly one LOAD cycle between them; no tick is lost, because the tick counter is free-running.
- If a tick coincides with LOAD, it is consumed by the LOAD and does not advance the phase.

## Configuration
- `NOTE_PLAYER_TRIANGLE_EN` defined: wave code 10 generates the triangle as specified above.
- Not defined: there is no triangle logic, and wave code 10 plays as square.

## Structure
- Package `note_player_pkg`:
  - wave encodings `WAVE_SQUARE`, `WAVE_SAW`, `WAVE_TRI`, `WAVE_REST`;
  - FSM state enum (`S_IDLE`, `S_LOAD`, `S_PLAY`);
  - `PHASE_W`=16 and `SAMPLE_W`=8.
- Sub-module `cmd_fifo`: synchronous FIFO with async active-low reset, 34-bit entries, parameter `FIFO_DEPTH`, and full/empty/count outputs.

## Test plan
All scenarios use SAMPLE_DIV=4.
- Reset: assert `reset`=0 mid-note → immediately `sample`=00, `silent`=1, `busy`=0, `cmd_ready`=1; the queued commands are never played.
- Square note, inc 16'h4000, dur 4:
  - `sample` sequence per tick: 7F (LOAD), 7F, 81, 81.
  - Then `silent`=1, `sample`=00, `busy`=0.
- Saw note, inc 16'h1000, dur 3 → 80, 90, A0, then silent.
- Triangle note, inc 16'h4000, dur 4:
  - With the macro defined → 80, 00, 7F, FF.
  - Without the macro → 7F, 7F, 81, 81.
- FIFO:
  - Push 5 commands back-to-back while a note plays → `cmd_ready` drops after the 4th push and rises on the next pop.
  - All commands play in order.
  - Simultaneous push and pop at count 1 leaves the count unchanged.
- Duration 0 followed by a rest of dur 2:
  - The first command is skipped with `silent`=1.
  - The rest holds `silent`=1, `sample`=00 for 2 ticks, with `busy`=1 throughout.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared types, widths and waveform lookup for the note_player tone generator.
// NOTE_PLAYER_TRIANGLE_EN enables the triangle waveform; otherwise code 10 plays as square.
package note_player_pkg;

  localparam int PHASE_W  = 16;
  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_REST   = 2'b11
  } wave_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  typedef struct packed {
    wave_t                wave;
    logic [PHASE_W-1:0]   duration;
    logic [PHASE_W-1:0]   phase_inc;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic [SAMPLE_W-1:0] wave_sample(input wave_t w,
                                                      input logic [PHASE_W-1:0] p);
    logic [SAMPLE_W-1:0] s;
    s = '0;
    case (w)
      WAVE_SAW:  s = p[15:8] ^ 8'h80;
`ifdef NOTE_PLAYER_TRIANGLE_EN
      WAVE_TRI:  s = (p[15] ? ~p[14:7] : p[14:7]) ^ 8'h80;
`endif
      WAVE_REST: s = '0;
      default:   s = p[15] ? 8'h81 : 8'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/note_player_cmd_fifo.sv
// Command FIFO for note_player: synchronous, power-of-two depth, async active-low reset.
module cmd_fifo
  import note_player_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [CMD_W-1:0]              din,
  output logic [CMD_W-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/note_player.sv
// Command-driven tone generator feeding the delta-sigma DAC (sample/silent).
// Define NOTE_PLAYER_TRIANGLE_EN to enable the triangle waveform.
module note_player
  import note_player_pkg::*;
#(
  parameter int SAMPLE_DIV = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [PHASE_W-1:0]         cmd_phase_inc,
  input  logic [PHASE_W-1:0]         cmd_duration,
  input  logic [1:0]                 cmd_wave,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       silent,
  output logic                       busy
);

  localparam int TW    = $clog2(SAMPLE_DIV);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [CMD_W-1:0]   head_raw;
  cmd_t               head;
  logic               more;

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W-1:0] dur;
  wave_t              cur_wave;

  cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({cmd_wave, cmd_duration, cmd_phase_inc}),
    .dout  (head_raw),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head       = cmd_t'(head_raw);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_LOAD);
  // FIFO occupancy after this cycle's pop, used to chain zero-length notes
  assign more       = (count > CNT_W'(1)) || push;
  assign phase_next = phase + inc;
  assign tick       = (tick_cnt == TICK_LAST);
  assign busy       = (state != S_IDLE) || !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      phase    <= '0;
      inc      <= '0;
      dur      <= '0;
      cur_wave <= WAVE_SQUARE;
      sample   <= '0;
      silent   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          sample <= '0;
          silent <= 1'b1;
          if (!empty) state <= S_LOAD;
        end
        S_LOAD: begin
          phase    <= '0;
          inc      <= head.phase_inc;
          dur      <= head.duration;
          cur_wave <= head.wave;
          if (head.duration == '0) begin
            sample <= '0;
            silent <= 1'b1;
            state  <= more ? S_LOAD : S_IDLE;
          end else begin
            sample <= wave_sample(head.wave, '0);
            silent <= (head.wave == WAVE_REST);
            state  <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick) begin
            phase  <= phase_next;
            dur    <= dur - PHASE_W'(1);
            sample <= wave_sample(cur_wave, phase_next);
            silent <= (cur_wave == WAVE_REST);
            if (dur == PHASE_W'(1)) begin
              if (!empty) begin
                state <= S_LOAD;
              end else begin
                state  <= S_IDLE;
                sample <= '0;
                silent <= 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Directed self-checking bench for note_player with SAMPLE_DIV=4, FIFO_DEPTH=4.
module tb_note_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_phase_inc;
  logic [15:0] cmd_duration;
  logic [1:0]  cmd_wave;
  logic [7:0]  sample;
  logic        silent;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference sample-rate counter: ticks every 4th cycle from reset release
  logic [1:0] tb_cnt;

  note_player #(.SAMPLE_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_phase_inc (cmd_phase_inc),
    .cmd_duration  (cmd_duration),
    .cmd_wave      (cmd_wave),
    .sample        (sample),
    .silent        (silent),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cnt <= 2'd0;
    else        tb_cnt <= (tb_cnt == 2'd3) ? 2'd0 : tb_cnt + 2'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the next rising edge on which a tick was active
  task automatic wait_tick();
    bit t;
    do begin
      @(negedge clk);
      t = (tb_cnt == 2'd3);
      @(posedge clk);
    end while (!t);
    #1;
  endtask

  task automatic push_cmd(input logic [15:0] inc, input logic [15:0] dur, input logic [1:0] wave);
    @(negedge clk);
    check("push_ready", 32'(cmd_ready), 32'd1);
    cmd_valid     = 1'b1;
    cmd_phase_inc = inc;
    cmd_duration  = dur;
    cmd_wave      = wave;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'({busy, silent, cmd_ready, sample}), 32'({1'b0, 1'b1, 1'b1, 8'h00}));
  endtask

  // Entered #1 after a LOAD edge; returns #1 after the note's final tick edge
  task automatic play_expect(input string tag, input logic [31:0] exps, input int n, input logic sil);
    check($sformatf("%s[0]", tag), 32'({busy, silent, sample}), 32'({1'b1, sil, exps[7:0]}));
    for (int i = 1; i < n; i++) begin
      wait_tick();
      check($sformatf("%s[%0d]", tag, i), 32'({busy, silent, sample}),
            32'({1'b1, sil, exps[8*i +: 8]}));
    end
    wait_tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tri_exp;
    int          guard;
`ifdef NOTE_PLAYER_TRIANGLE_EN
    tri_exp = {8'hFF, 8'h7F, 8'h00, 8'h80};
`else
    tri_exp = {8'h81, 8'h81, 8'h7F, 8'h7F};
`endif
    reset         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_phase_inc = '0;
    cmd_duration  = '0;
    cmd_wave      = '0;
    repeat (3) @(posedge clk);
    #1 check_idle("in_reset");
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_idle("after_reset");

    push_cmd(16'h4000, 16'd4, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    play_expect("square", 32'h81817F7F, 4, 1'b0);
    check_idle("square_end");

    push_cmd(16'h1000, 16'd3, 2'b01);
    @(posedge clk); @(posedge clk); #1;
    play_expect("saw", 32'h00A09080, 3, 1'b0);
    check_idle("saw_end");

    push_cmd(16'h4000, 16'd4, 2'b10);
    @(posedge clk); @(posedge clk); #1;
    play_expect("tri", tri_exp, 4, 1'b0);
    check_idle("tri_end");

    push_cmd(16'h1000, 16'd0, 2'b00);
    push_cmd(16'h0100, 16'd2, 2'b11);
    @(posedge clk); #1;
    check("zero_dur", 32'({busy, silent, sample}), 32'({1'b1, 1'b1, 8'h00}));
    @(posedge clk); #1;
    play_expect("rest", 32'h0, 2, 1'b1);
    check_idle("rest_end");

    // Five back-to-back pushes while a long note plays; then check playback order
    push_cmd(16'h4000, 16'd6, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    check("fifo_a_load", 32'({busy, silent, sample}), 32'({1'b1, 1'b0, 8'h7F}));
    fork
      begin : pusher
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          cmd_valid     = 1'b1;
          cmd_phase_inc = 16'((k + 1) * 4096);
          cmd_duration  = 16'd2;
          cmd_wave      = 2'b01;
          if (k < 4) begin
            check($sformatf("ready_push%0d", k), 32'(cmd_ready), 32'd1);
            @(posedge clk);
          end else begin
            check("ready_full", 32'(cmd_ready), 32'd0);
            guard = 0;
            while (!cmd_ready && guard < 200) begin
              @(negedge clk);
              guard++;
            end
            check("ready_rise_timeout", 32'(guard < 200), 32'd1);
            @(posedge clk);
          end
          #1 cmd_valid = 1'b0;
        end
      end
      begin : player
        repeat (6) wait_tick();
        @(negedge clk);
        check("full_at_a_end", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_pop", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
          play_expect($sformatf("order%0d", k),
                      {16'h0, 8'h80 ^ 8'((k + 1) * 16), 8'h80}, 2, 1'b0);
          if (k < 4) begin
            @(posedge clk); #1;
          end
        end
        check_idle("fifo_drain");
      end
    join

    // Push coinciding with the LOAD pop at count 1 must leave count at 1
    push_cmd(16'h2000, 16'd4, 2'b00);
    @(posedge clk);
    push_cmd(16'h1000, 16'd1, 2'b01);
    check("x_load", 32'({busy, silent, sample}), 32'({1'b1, 1'b0, 8'h7F}));
    push_cmd(16'h1000, 16'd1, 2'b00);
    push_cmd(16'h1000, 16'd1, 2'b00);
    check("count3_ready", 32'(cmd_ready), 32'd1);
    push_cmd(16'h1000, 16'd1, 2'b00);
    check("count4_full", 32'(cmd_ready), 32'd0);
    guard = 0;
    while (busy && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_timeout", 32'(guard < 400), 32'd1);
    check_idle("drain_idle");

    // Asynchronous reset mid-note discards the queued commands
    push_cmd(16'h4000, 16'd8, 2'b00);
    push_cmd(16'h1000, 16'd3, 2'b01);
    push_cmd(16'h1000, 16'd3, 2'b01);
    wait_tick();
    wait_tick();
    check("busy_mid_note", 32'({busy, silent}), 32'({1'b1, 1'b0}));
    #1 reset = 1'b0;
    #1 check_idle("reset_async");
    @(negedge clk) reset = 1'b1;
    repeat (40) @(posedge clk);
    #1 check_idle("queued_dropped");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
